// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared LCD geometry, scan-out state encoding and address helper
// Revision: 1.0
// ============================================================================
package lcd_pkg;

  localparam int LCD_COLS  = 132;
  localparam int LCD_W     = 96;
  localparam int LCD_H     = 64;
  localparam int LCD_PAGES = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } scan_state_t;

  // Display RAM is page-major: each 8-line page occupies LCD_COLS bytes.
  function automatic logic [10:0] pixel_address(input logic [3:0] page,
                                                input logic [7:0] column);
    return 11'(int'(page) * LCD_COLS + int'(column));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_line_map.sv
`default_nettype none
// ============================================================================
// lcd_line_map : maps a visible row to its display RAM page and bit
// Revision: 1.0
// ============================================================================
module lcd_line_map (
  input  logic [5:0] y_i,
  input  logic [5:0] start_line_i,
  input  logic       row_order_i,
  output logic [2:0] page_o,
  output logic [2:0] bit_o
);

  logic [5:0] line;

  // 6-bit sum wraps mod 64, so page 8 is unreachable.
  always_comb begin
    line   = (row_order_i ? (6'd63 - y_i) : y_i) + start_line_i;
    page_o = line[5:3];
    bit_o  = line[2:0];
  end

endmodule
`default_nettype wire

// File: rtl/lcd_scanout.sv
`default_nettype none
// ============================================================================
// lcd_scanout : walks display RAM once per frame, emits a 1-bit pixel stream
// Revision: 1.0
// ============================================================================
module lcd_scanout
  import lcd_pkg::*;
#(
  parameter int WIDTH    = 96,
  parameter int HEIGHT   = 64,
  parameter int LCD_COLS = 132
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [5:0]  start_line,
  input  logic        row_order,
  input  logic        display_enabled,
  input  logic        all_pixels_on,
  input  logic        invert_pixels,
  output logic        mem_rd,
  output logic [10:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

  scan_state_t state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [5:0]  start_line_q, start_line_d;
  logic        row_order_q, row_order_d;
  logic        enabled_q, enabled_d;
  logic        all_on_q, all_on_d;
  logic        invert_q, invert_d;
  logic        pix_q, pix_d;
  logic        done_q, done_d;

  logic [2:0]  page;
  logic [2:0]  bit_sel;
  logic        at_last;

  lcd_line_map u_line_map (
    .y_i          (y_q),
    .start_line_i (start_line_q),
    .row_order_i  (row_order_q),
    .page_o       (page),
    .bit_o        (bit_sel)
  );

  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      start_line_q <= '0;
      row_order_q  <= 1'b0;
      enabled_q    <= 1'b0;
      all_on_q     <= 1'b0;
      invert_q     <= 1'b0;
      pix_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      start_line_q <= start_line_d;
      row_order_q  <= row_order_d;
      enabled_q    <= enabled_d;
      all_on_q     <= all_on_d;
      invert_q     <= invert_d;
      pix_q        <= pix_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    start_line_d = start_line_q;
    row_order_d  = row_order_q;
    enabled_d    = enabled_q;
    all_on_d     = all_on_q;
    invert_d     = invert_q;
    pix_d        = pix_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          start_line_d = start_line;
          row_order_d  = row_order;
          enabled_d    = display_enabled;
          all_on_d     = all_pixels_on;
          invert_d     = invert_pixels;
          x_d          = '0;
          y_d          = '0;
          state_d      = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        // RAM is still read with the display off so frame timing never changes.
        if (!enabled_q)    pix_d = 1'b0;
        else if (all_on_q) pix_d = 1'b1;
        else               pix_d = mem_data[bit_sel] ^ invert_q;
        state_d = EMIT;
      end
      EMIT: begin
        if (pix_ready) begin
          if (at_last) begin
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (x_q == X_LAST) begin
            x_d     = '0;
            y_d     = y_q + 6'd1;
            state_d = FETCH;
          end else begin
            x_d     = x_q + 7'd1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd     = (state_q == FETCH);
  assign mem_addr   = (state_q == FETCH) ? 11'(int'(page) * LCD_COLS + int'(x_q)) : '0;
  assign pix_valid  = (state_q == EMIT);
  assign pix_data   = pix_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_last   = (state_q == EMIT) && at_last;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_scanout.sv
`default_nettype none
// ============================================================================
// tb_lcd_scanout : directed self-checking bench for lcd_scanout
// Revision: 1.0
// ============================================================================
module tb_lcd_scanout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [5:0]  start_line = '0;
  logic        row_order = 1'b0;
  logic        display_enabled = 1'b1;
  logic        all_pixels_on = 1'b0;
  logic        invert_pixels = 1'b0;
  logic        mem_rd;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_data;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic        pix_last;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram [0:2047];
  logic        got_pix [0:6143];
  logic [10:0] addr_log [$];
  int hs_count = 0;
  int done_count = 0;
  int last_ok = 0;
  int last_bad = 0;

  lcd_scanout #(.WIDTH(96), .HEIGHT(64), .LCD_COLS(132)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .start_line      (start_line),
    .row_order       (row_order),
    .display_enabled (display_enabled),
    .all_pixels_on   (all_pixels_on),
    .invert_pixels   (invert_pixels),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_last        (pix_last),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= ram[mem_addr];
      addr_log.push_back(mem_addr);
    end
  end

  always @(posedge clk) begin
    if (frame_done) done_count <= done_count + 1;
    if (pix_valid && pix_ready) begin
      hs_count <= hs_count + 1;
      got_pix[int'(pix_y) * 96 + int'(pix_x)] <= pix_data;
      if (pix_last && pix_x == 7'd95 && pix_y == 6'd63) last_ok <= last_ok + 1;
      else if (pix_last || (pix_x == 7'd95 && pix_y == 6'd63)) last_bad <= last_bad + 1;
    end
  end

  task automatic clear_ram();
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
  endtask

  task automatic start_frame(input logic [5:0] sl, input logic ro, input logic de,
                             input logic apo, input logic inv);
    start_line = sl; row_order = ro; display_enabled = de;
    all_pixels_on = apo; invert_pixels = inv;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic abort_frame();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    int budget = (target - hs_count) * 4 + 20;
    while (hs_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (hs_count < target) begin
      errors++;
      $display("FAIL %s_timeout: handshakes %0d required %0d", name, hs_count, target);
    end
  endtask

  task automatic test_reset();
    logic [29:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    v = {mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, frame_done};
    checks++;
    if (v !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", v);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b mem_rd=%b required 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_basic();
    int base_a, base_h, bad;
    clear_ram();
    ram[0] = 8'h01;
    base_a = addr_log.size();
    base_h = hs_count;
    start_frame(6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 11'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_fetch: mem_rd=%b addr=%0d busy=%b required 1 0 1", mem_rd, mem_addr, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_rd !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait: mem_rd=%b pix_valid=%b required 0 0", mem_rd, pix_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y} !== {1'b1, 1'b1, 7'd0, 6'd0}) begin
      errors++;
      $display("FAIL basic_emit: valid=%b data=%b x=%0d y=%0d required 1 1 0 0", pix_valid, pix_data, pix_x, pix_y);
    end
    wait_hs(base_h + 192, "basic");
    checks++;
    if (got_pix[0] !== 1'b1 || got_pix[1] !== 1'b0 || got_pix[96] !== 1'b0) begin
      errors++;
      $display("FAIL basic_pixels: (0,0)=%b (1,0)=%b (0,1)=%b required 1 0 0", got_pix[0], got_pix[1], got_pix[96]);
    end
    bad = 0;
    for (int i = 0; i < 96; i++) if (addr_log[base_a + i] !== 11'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_row0_addr: %0d wrong addresses required 0", bad);
    end
    abort_frame();
  endtask

  task automatic test_start_line();
    int base_h;
    clear_ram();
    ram[132] = 8'h04;
    ram[133] = 8'hFB;
    base_h = hs_count;
    start_frame(6'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_addr !== 11'd132) begin
      errors++;
      $display("FAIL sl10_addr: got %0d required 132", mem_addr);
    end
    wait_hs(base_h + 2, "sl10");
    checks++;
    if (got_pix[0] !== 1'b1 || got_pix[1] !== 1'b0) begin
      errors++;
      $display("FAIL sl10_pixels: (0,0)=%b (1,0)=%b required 1 0", got_pix[0], got_pix[1]);
    end
    abort_frame();
  endtask

  task automatic test_row_order();
    int base_a, base_h;
    clear_ram();
    ram[924] = 8'h80;
    ram[925] = 8'h7F;
    base_h = hs_count;
    start_frame(6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_addr !== 11'd924) begin
      errors++;
      $display("FAIL rev_addr: got %0d required 924", mem_addr);
    end
    wait_hs(base_h + 2, "rev");
    checks++;
    if (got_pix[0] !== 1'b1 || got_pix[1] !== 1'b0) begin
      errors++;
      $display("FAIL rev_pixels: (0,0)=%b (1,0)=%b required 1 0", got_pix[0], got_pix[1]);
    end
    abort_frame();
    // start_line 60: y=0 -> line 60 (page 7), y=4 -> line 0, y=5 -> line 1
    clear_ram();
    ram[0] = 8'h02;
    base_a = addr_log.size();
    base_h = hs_count;
    start_frame(6'd60, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_hs(base_h + 577, "sl60");
    checks++;
    if (addr_log[base_a] !== 11'd924 || addr_log[base_a + 480] !== 11'd0) begin
      errors++;
      $display("FAIL sl60_addr: y0=%0d y5=%0d required 924 0", addr_log[base_a], addr_log[base_a + 480]);
    end
    checks++;
    if (got_pix[384] !== 1'b0 || got_pix[480] !== 1'b1 || got_pix[576] !== 1'b0) begin
      errors++;
      $display("FAIL sl60_pixels: y4=%b y5=%b y6=%b required 0 1 0", got_pix[384], got_pix[480], got_pix[576]);
    end
    abort_frame();
  endtask

  task automatic test_backpressure();
    int base_h, n;
    clear_ram();
    ram[3] = 8'h04;
    base_h = hs_count;
    start_frame(6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_hs(base_h + 195, "bp_reach");
    pix_ready = 1'b0;
    n = 0;
    while (!pix_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({pix_valid, pix_data, pix_x, pix_y, pix_last, mem_rd} !==
          {1'b1, 1'b1, 7'd3, 6'd2, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%b x=%0d y=%0d last=%b rd=%b required 1 1 3 2 0 0",
                 i, pix_valid, pix_data, pix_x, pix_y, pix_last, mem_rd);
      end
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 11'd4 || hs_count != base_h + 196) begin
      errors++;
      $display("FAIL bp_release: rd=%b addr=%0d hs=%0d required 1 4 %0d", mem_rd, mem_addr, hs_count, base_h + 196);
    end
    abort_frame();
  endtask

  task automatic test_modes();
    int base_a, base_h, bad;
    clear_ram();
    base_a = addr_log.size();
    base_h = hs_count;
    start_frame(6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    start_line = 6'd5; row_order = 1'b1; display_enabled = 1'b0; invert_pixels = 1'b0;
    wait_hs(base_h + 100, "invert");
    bad = 0;
    for (int i = 0; i < 100; i++) if (got_pix[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL invert_pixels: %0d pixels not 1 required 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 96; i++) if (addr_log[base_a + i] !== 11'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL live_toggle_addr: %0d wrong addresses required 0", bad);
    end
    abort_frame();
    base_h = hs_count;
    start_frame(6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    display_enabled = 1'b1;
    wait_hs(base_h + 100, "disabled");
    bad = 0;
    for (int i = 0; i < 100; i++) if (got_pix[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL disabled_pixels: %0d pixels not 0 required 0", bad);
    end
    abort_frame();
  endtask

  task automatic test_full_frame();
    int h0, d0, lok0, lbad0, n;
    clear_ram();
    h0 = hs_count; d0 = done_count; lok0 = last_ok; lbad0 = last_bad;
    start_frame(6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_hs(h0 + 1000, "full_mid");
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 0;
    while (!frame_done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done: frame_done=%b busy=%b required 1 0", frame_done, busy);
    end
    checks++;
    if (hs_count - h0 != 6144) begin
      errors++;
      $display("FAIL full_handshakes: got %0d required 6144", hs_count - h0);
    end
    checks++;
    if (last_ok - lok0 != 1 || last_bad - lbad0 != 0) begin
      errors++;
      $display("FAIL full_last: ok=%0d bad=%0d required 1 0", last_ok - lok0, last_bad - lbad0);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_count - d0 != 1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_after: dones=%0d busy=%b valid=%b required 1 0 0", done_count - d0, busy, pix_valid);
    end
  endtask

  task automatic test_reset_midframe();
    int base_h;
    logic [29:0] v;
    base_h = hs_count;
    start_frame(6'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_hs(base_h + 100, "midreset");
    reset = 1'b1;
    @(posedge clk); #1;
    v = {mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, frame_done};
    checks++;
    if (v !== 30'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0", v);
    end
    reset = 1'b0;
  endtask

  initial begin
    clear_ram();
    test_reset();
    test_basic();
    test_start_line();
    test_row_order();
    test_backpressure();
    test_modes();
    test_full_frame();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
